mac_reg_arbiter: RTL and testbench
==================================

MAC_REG_ARBITER -- requirements
Module: mac_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of ACCESS cycles tolerated while mac_reg_busy is high.
REQ-002 SHALL have ports, one per line, as listed below. Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  per-requester command valid
- req_wr  in  2  per-requester 1=write, 0=read
- req_addr  in  16  requester i address at [8i+7:8i]
- req_wdata  in  64  requester i write data at [32i+31:32i]
- req_ready  out  2  per-requester command accepted
- rsp_valid  out  2  per-requester response strobe
- rsp_rdata  out  32  shared read data
- rsp_err  out  1  response error flag
- mac_reg_addr  out  8  MAC register address
- mac_reg_din  out  32  MAC write data
- mac_reg_rd  out  1  MAC read strobe
- mac_reg_wr  out  1  MAC write strobe
- mac_reg_busy  in  1  MAC wait request
- mac_reg_dout  in  32  MAC read data

Function
REQ-003 SHALL share one MAC control-register port between two requesters: requester 0 is the config sequencer and requester 1 is the statistics poller.
REQ-004 SHALL implement three states: IDLE, ACCESS and RESP.
REQ-005 In IDLE with any req_valid high, SHALL assert req_ready[g] combinationally for one cycle, latch g's wr/addr/wdata, and enter ACCESS.
REQ-006 SHALL select g round-robin: when both requesters are valid, grant the requester other than last_grant; last_grant SHALL update on the handshake.
REQ-007 In ACCESS, SHALL hold exactly one of mac_reg_rd/mac_reg_wr high, with mac_reg_addr and mac_reg_din stable, until the first cycle with mac_reg_busy low.
REQ-008 Strobe latency from handshake SHALL be exactly 1 cycle.
REQ-009 On the completing ACCESS cycle, SHALL capture mac_reg_dout for reads and enter RESP.
REQ-010 In RESP, SHALL pulse rsp_valid[g] for exactly 1 cycle, with rsp_rdata = captured data (0 for writes) and rsp_err=0, deassert the strobes, then return to IDLE.
REQ-011 Minimum transaction length SHALL be 3 cycles; req_ready SHALL NOT assert outside IDLE.
REQ-012 req_valid changes after the handshake SHALL NOT affect the transaction in flight; requesters hold their payload until req_ready.
REQ-013 mac_reg_rd and mac_reg_wr SHALL never be high simultaneously.
REQ-014 Outside ACCESS, mac_reg_addr, mac_reg_din, mac_reg_rd and mac_reg_wr SHALL be 0.

Reset
REQ-015 rst SHALL immediately force IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie.
REQ-016 Reset mid-ACCESS SHALL drop the strobes asynchronously, produce no response, and discard the latched command.

Configuration
REQ-017 With MAC_REG_ARB_TIMEOUT_EN defined, SHALL count ACCESS cycles with mac_reg_busy high. When the count reaches TIMEOUT_CYCLES, SHALL abort to RESP with rsp_err=1 and rsp_rdata=32'hDEADBEEF; the counter SHALL clear on entering ACCESS.
REQ-018 Without MAC_REG_ARB_TIMEOUT_EN, SHALL wait indefinitely in ACCESS, rsp_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-019 Single write: req0 write addr 8'h02 data 32'h00800223 with busy low -> req_ready[0] in cycle 0, mac_reg_wr=1 in cycle 1, rsp_valid[0] in cycle 2, rsp_rdata=0.
REQ-020 Read with busy: req1 read addr 8'h0F, busy high for 4 cycles, mac_reg_dout=32'h00000001 -> strobe held 5 cycles, then rsp_valid[1] with rsp_rdata=32'h00000001.
REQ-021 Contention: both requesters valid continuously for 4 transactions after reset -> grants are 0,1,0,1 and no cycle has both strobes high.
REQ-022 Reset mid-access: assert rst during the 2nd busy cycle -> strobes 0 the same cycle, no rsp_valid, and the next request is served normally.
REQ-023 Timeout (macro on, TIMEOUT_CYCLES=8): busy held high -> abort after 8 busy cycles with rsp_err=1 and rsp_rdata=32'hDEADBEEF; with the macro off, the block remains in ACCESS.

Source files
------------

// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing one MAC control-register port between two requesters.
// Define MAC_REG_ARB_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES busy cycles.
module mac_reg_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_wr,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  mac_reg_addr,
  output logic [31:0] mac_reg_din,
  output logic        mac_reg_rd,
  output logic        mac_reg_wr,
  input  logic        mac_reg_busy,
  input  logic [31:0] mac_reg_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q;
  logic        last_grant_q, gnt_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [7:0]  addr_q;
  logic [31:0] din_q;
  logic        rd_q, wr_q;
  logic        gnt_d, any_req, done, abort;

  // Tie goes to the requester that did not win last time.
  assign any_req = |req_valid;
  assign gnt_d   = (&req_valid) ? ~last_grant_q : req_valid[1];

  assign req_ready    = (state_q == IDLE && any_req) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mac_reg_addr = addr_q;
  assign mac_reg_din  = din_q;
  assign mac_reg_rd   = rd_q;
  assign mac_reg_wr   = wr_q;

`ifdef MAC_REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          rsp_err_q;

  assign abort   = mac_reg_busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) cnt_q <= '0;
      else if (state_q == ACCESS && mac_reg_busy && !abort) cnt_q <= cnt_q + 1'b1;
      if (state_q == ACCESS && abort) rsp_err_q <= 1'b1;
      else if (state_q == RESP)       rsp_err_q <= 1'b0;
    end
  end
`else
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign done = !mac_reg_busy || abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          state_q      <= ACCESS;
          gnt_q        <= gnt_d;
          last_grant_q <= gnt_d;
          addr_q       <= gnt_d ? req_addr[15:8]   : req_addr[7:0];
          din_q        <= gnt_d ? req_wdata[63:32] : req_wdata[31:0];
          wr_q         <= req_wr[gnt_d];
          rd_q         <= ~req_wr[gnt_d];
        end
        ACCESS: if (done) begin
          state_q            <= RESP;
          rsp_valid_q[gnt_q] <= 1'b1;
          rsp_rdata_q        <= abort ? 32'hDEADBEEF : (rd_q ? mac_reg_dout : 32'h0);
          addr_q             <= '0;
          din_q              <= '0;
          rd_q               <= 1'b0;
          wr_q               <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 2'b00;
          rsp_rdata_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Directed bench for mac_reg_arbiter: inputs driven at negedge, outputs checked 1ns later.
module tb_mac_reg_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_wr, req_ready, rsp_valid;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mac_reg_din, mac_reg_dout;
  logic        rsp_err, mac_reg_rd, mac_reg_wr, mac_reg_busy;
  logic [7:0]  mac_reg_addr;

  int n_chk = 0;
  int n_err = 0;

  mac_reg_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mac_reg_addr(mac_reg_addr), .mac_reg_din(mac_reg_din),
    .mac_reg_rd(mac_reg_rd), .mac_reg_wr(mac_reg_wr), .mac_reg_busy(mac_reg_busy),
    .mac_reg_dout(mac_reg_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_strb"}, {30'd0, mac_reg_rd, mac_reg_wr}, 32'd0);
    chk({tag, "_addr"}, {24'd0, mac_reg_addr}, 32'd0);
    chk({tag, "_din"}, mac_reg_din, 32'd0);
  endtask

  task automatic do_reset();
    cyc(); rst = 1'b1; req_valid = 2'b00;
    cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
    mac_reg_busy = 1'b0; mac_reg_dout = '0;
    #1;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rspv", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk_idle_outs("rst");
    cyc(); rst = 1'b0;

    // Single write, busy low
    cyc(); req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h0002; req_wdata = 64'h0000_0000_0080_0223;
    #1 chk("w_ready", {30'd0, req_ready}, 32'h1);
    cyc(); req_valid = 2'b00;
    #1 chk("w_wr", {30'd0, mac_reg_rd, mac_reg_wr}, 32'h1);
    chk("w_addr", {24'd0, mac_reg_addr}, 32'h02);
    chk("w_din", mac_reg_din, 32'h00800223);
    chk("w_noready", {30'd0, req_ready}, 32'd0);
    cyc(); #1 chk("w_rspv", {30'd0, rsp_valid}, 32'h1);
    chk("w_rdata", rsp_rdata, 32'd0);
    chk("w_err", {31'd0, rsp_err}, 32'd0);
    chk_idle_outs("w_resp");
    cyc(); #1 chk("w_rspv_off", {30'd0, rsp_valid}, 32'd0);

    // Read on requester 1 with 4 busy cycles
    req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h0F00; mac_reg_busy = 1'b1; mac_reg_dout = 32'h1;
    #1 chk("r_ready", {30'd0, req_ready}, 32'h2);
    for (int k = 0; k < 5; k++) begin
      cyc(); req_valid = 2'b00; mac_reg_busy = (k < 4);
      #1 chk($sformatf("r_strb%0d", k), {30'd0, mac_reg_rd, mac_reg_wr}, 32'h2);
      chk($sformatf("r_addr%0d", k), {24'd0, mac_reg_addr}, 32'h0F);
    end
    cyc(); #1 chk("r_rspv", {30'd0, rsp_valid}, 32'h2);
    chk("r_rdata", rsp_rdata, 32'h1);
    chk_idle_outs("r_resp");

    // Contention after reset: grants alternate starting with requester 0
    do_reset();
    req_valid = 2'b11; req_wr = 2'b01; req_addr = 16'hA5_5A; req_wdata = 64'h1111_1111_2222_2222;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) cyc();
      #1 chk($sformatf("c_ready%0d", t), {30'd0, req_ready}, (t % 2) ? 32'h2 : 32'h1);
      cyc(); #1 chk($sformatf("c_strb%0d", t), {30'd0, mac_reg_rd, mac_reg_wr}, (t % 2) ? 32'h2 : 32'h1);
      chk($sformatf("c_addr%0d", t), {24'd0, mac_reg_addr}, (t % 2) ? 32'hA5 : 32'h5A);
      cyc(); #1 chk($sformatf("c_rspv%0d", t), {30'd0, rsp_valid}, (t % 2) ? 32'h2 : 32'h1);
      chk($sformatf("c_noready%0d", t), {30'd0, req_ready}, 32'd0);
    end
    cyc(); req_valid = 2'b00;

    // Reset during the second busy cycle
    cyc(); req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h0044; req_wdata = 64'h55; mac_reg_busy = 1'b1;
    #1 chk("x_ready", {30'd0, req_ready}, 32'h1);
    cyc(); req_valid = 2'b00;
    cyc(); #1 chk("x_wr_before", {30'd0, mac_reg_rd, mac_reg_wr}, 32'h1);
    rst = 1'b1;
    #1 chk_idle_outs("x_rst");
    cyc(); rst = 1'b0; mac_reg_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1 chk($sformatf("x_norsp%0d", k), {30'd0, rsp_valid}, 32'd0);
    end
    req_valid = 2'b10; req_wr = 2'b00; req_addr = 16'h3300; mac_reg_dout = 32'h12345678;
    #1 chk("x2_ready", {30'd0, req_ready}, 32'h2);
    cyc(); req_valid = 2'b00;
    #1 chk("x2_rd", {30'd0, mac_reg_rd, mac_reg_wr}, 32'h2);
    chk("x2_addr", {24'd0, mac_reg_addr}, 32'h33);
    cyc(); #1 chk("x2_rspv", {30'd0, rsp_valid}, 32'h2);
    chk("x2_rdata", rsp_rdata, 32'h12345678);

    // Busy stuck high
    cyc(); req_valid = 2'b01; req_wr = 2'b01; req_addr = 16'h0077; mac_reg_busy = 1'b1;
    #1 chk("t_ready", {30'd0, req_ready}, 32'h1);
`ifdef MAC_REG_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      cyc(); req_valid = 2'b00;
      #1 chk($sformatf("t_wr%0d", k), {30'd0, mac_reg_rd, mac_reg_wr}, 32'h1);
    end
    cyc(); #1 chk("t_rspv", {30'd0, rsp_valid}, 32'h1);
    chk("t_err", {31'd0, rsp_err}, 32'h1);
    chk("t_rdata", rsp_rdata, 32'hDEADBEEF);
    chk_idle_outs("t_resp");
    cyc(); #1 chk("t_err_off", {31'd0, rsp_err}, 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      cyc(); req_valid = 2'b00;
      #1 chk($sformatf("t_wr%0d", k), {30'd0, mac_reg_rd, mac_reg_wr}, 32'h1);
      chk($sformatf("t_norsp%0d", k), {30'd0, rsp_valid}, 32'd0);
    end
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Strobes must never overlap
  always @(negedge clk) begin
    if (!rst) chk("onehot", {31'd0, mac_reg_rd & mac_reg_wr}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
